// File: rtl/lab4_alu_pkg.sv
// Shared definitions for the lab4_alu command sequencer.
//   - func-code class patterns and masks used to classify ALU function codes
//   - FSM state encodings for the sequencer
//   - packed command record carried through the command FIFO
//   - helpers that classify a func code and tell whether it is legal
package lab4_alu_pkg;

    // A func code belongs to a class when (func & MASK) == PATTERN.
    localparam logic [4:0] FUNC_SHIFT       = 5'b00000;
    localparam logic [4:0] FUNC_SHIFT_MASK  = 5'b11000;
    localparam logic [4:0] FUNC_MULDIV      = 5'b10000;
    localparam logic [4:0] FUNC_MULDIV_MASK = 5'b11100;
    localparam logic [4:0] FUNC_ADDSUB      = 5'b10110;
    localparam logic [4:0] FUNC_ADDSUB_MASK = 5'b11110;
    localparam logic [4:0] FUNC_LOGIC       = 5'b11000;
    localparam logic [4:0] FUNC_LOGIC_MASK  = 5'b11100;

    // Sequencer states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [2:0] {
        CLS_SHIFT,
        CLS_MULDIV,
        CLS_ADDSUB,
        CLS_LOGIC,
        CLS_ILLEGAL
    } func_class_t;

    // One queued operation: 32 + 32 + 5 = 69 bits.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  func;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    function automatic func_class_t func_class(input logic [4:0] func);
        func_class_t cls;
        cls = CLS_ILLEGAL;
        if ((func & FUNC_SHIFT_MASK) == FUNC_SHIFT) begin
            cls = CLS_SHIFT;
        end else if ((func & FUNC_MULDIV_MASK) == FUNC_MULDIV) begin
            cls = CLS_MULDIV;
        end else if ((func & FUNC_ADDSUB_MASK) == FUNC_ADDSUB) begin
            cls = CLS_ADDSUB;
        end else if ((func & FUNC_LOGIC_MASK) == FUNC_LOGIC) begin
            cls = CLS_LOGIC;
        end
        return cls;
    endfunction

    function automatic logic func_legal(input logic [4:0] func);
        return func_class(func) != CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/lab4_alu_seq_fifo.sv
// alu_cmd_fifo: synchronous FIFO for queued ALU commands.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (empties the FIFO)
//   push       write push_data when not full
//   push_data  entry to enqueue
//   pop        drop the head entry when not empty
//   pop_data   current head entry (valid while !empty)
//   full       DEPTH entries stored
//   empty      no entries stored
// Push and pop in the same cycle are both honoured; the count is unchanged.
module alu_cmd_fifo
    import lab4_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/lab4_alu_seq.sv
// lab4_alu_seq: command-side sequencer for the combinational lab4_alu.
// Queues operation requests, presents each one to the ALU for a
// class-dependent settle time, captures result/flags and returns them
// on a valid/ready response channel. At most one operation is in flight.
// Ports:
//   in_clk / in_rst_n                   clock, asynchronous active-low reset
//   in_cmd_valid / out_cmd_ready        command handshake
//   in_cmd_A / in_cmd_B / in_cmd_func   command operands and function code
//   out_alu_A / out_alu_B / out_alu_func       drive the ALU inputs
//   in_alu_result / in_alu_overflow / in_alu_zero  ALU outputs
//   out_rsp_valid / in_rsp_ready        response handshake
//   out_rsp_result / _overflow / _zero / _illegal  captured response
//   out_busy                            FIFO non-empty or an op in flight
module lab4_alu_seq
    import lab4_alu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int MULDIV_WAIT = 4,
    parameter int BASE_WAIT   = 1
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_cmd_valid,
    output logic        out_cmd_ready,
    input  logic [31:0] in_cmd_A,
    input  logic [31:0] in_cmd_B,
    input  logic [4:0]  in_cmd_func,
    output logic [31:0] out_alu_A,
    output logic [31:0] out_alu_B,
    output logic [4:0]  out_alu_func,
    input  logic [31:0] in_alu_result,
    input  logic        in_alu_overflow,
    input  logic        in_alu_zero,
    output logic        out_rsp_valid,
    input  logic        in_rsp_ready,
    output logic [31:0] out_rsp_result,
    output logic        out_rsp_overflow,
    output logic        out_rsp_zero,
    output logic        out_rsp_illegal,
    output logic        out_busy
);

    localparam int MAX_WAIT = (MULDIV_WAIT > BASE_WAIT) ? MULDIV_WAIT : BASE_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_WAIT - 1);
    localparam logic [CNT_W-1:0] BASE_LOAD   = CNT_W'(BASE_WAIT - 1);

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;

    alu_cmd_t    push_cmd;
    alu_cmd_t    head_cmd;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    func_class_t head_class;
    func_class_t cur_class;

    // Ready depends only on the stored FIFO level (and reset), never on
    // this cycle's pop, so there is no combinational path through the FSM.
    assign out_cmd_ready = in_rst_n && !fifo_full;
    assign fifo_push     = in_cmd_valid && out_cmd_ready;
    assign fifo_pop      = (state_reg == ST_IDLE) && !fifo_empty;
    assign out_busy      = !fifo_empty || (state_reg != ST_IDLE);

    assign push_cmd.a    = in_cmd_A;
    assign push_cmd.b    = in_cmd_B;
    assign push_cmd.func = in_cmd_func;

    assign head_class = func_class(head_cmd.func);
    // The in-flight func stays on out_alu_func, so decode from there.
    assign cur_class  = func_class(out_alu_func);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            out_alu_A        <= '0;
            out_alu_B        <= '0;
            out_alu_func     <= '0;
            out_rsp_valid    <= 1'b0;
            out_rsp_result   <= '0;
            out_rsp_overflow <= 1'b0;
            out_rsp_zero     <= 1'b0;
            out_rsp_illegal  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        out_alu_A    <= head_cmd.a;
                        out_alu_B    <= head_cmd.b;
                        out_alu_func <= head_cmd.func;
                        if (head_class != CLS_ILLEGAL) begin
                            cnt_reg   <= (head_class == CLS_MULDIV) ? MULDIV_LOAD : BASE_LOAD;
                            state_reg <= ST_WAIT;
                        end else begin
                            // Illegal codes skip the ALU entirely.
                            out_rsp_result   <= '0;
                            out_rsp_overflow <= 1'b0;
                            out_rsp_zero     <= 1'b0;
                            out_rsp_illegal  <= 1'b1;
                            out_rsp_valid    <= 1'b1;
                            state_reg        <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        out_rsp_result <= in_alu_result;
                        out_rsp_zero   <= in_alu_zero;
                        // Overflow is only meaningful for add/sub.
                        out_rsp_overflow <= (cur_class == CLS_ADDSUB) ? in_alu_overflow : 1'b0;
                        out_rsp_illegal  <= 1'b0;
                        out_rsp_valid    <= 1'b1;
                        state_reg        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (in_rsp_ready) begin
                        out_rsp_valid <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab4_alu_seq.sv
module tb_lab4_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_A;
    logic [31:0] cmd_B;
    logic [4:0]  cmd_func;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [4:0]  alu_func;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        rsp_illegal;
    logic        busy;
    logic        ovf_drive;

    int checks = 0;
    int errors = 0;

    lab4_alu_seq dut (
        .in_clk           (clk),
        .in_rst_n         (rst_n),
        .in_cmd_valid     (cmd_valid),
        .out_cmd_ready    (cmd_ready),
        .in_cmd_A         (cmd_A),
        .in_cmd_B         (cmd_B),
        .in_cmd_func      (cmd_func),
        .out_alu_A        (alu_A),
        .out_alu_B        (alu_B),
        .out_alu_func     (alu_func),
        .in_alu_result    (alu_result),
        .in_alu_overflow  (alu_overflow),
        .in_alu_zero      (alu_zero),
        .out_rsp_valid    (rsp_valid),
        .in_rsp_ready     (rsp_ready),
        .out_rsp_result   (rsp_result),
        .out_rsp_overflow (rsp_overflow),
        .out_rsp_zero     (rsp_zero),
        .out_rsp_illegal  (rsp_illegal),
        .out_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational ALU; unknown codes return a marker.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_func)
            5'b10110: alu_result = alu_A + alu_B;
            5'b10111: alu_result = alu_A - alu_B;
            5'b10000: alu_result = alu_A * alu_B;
            5'b11010: alu_result = alu_A ^ alu_B;
            5'b00000: alu_result = alu_A << alu_B[4:0];
            default:  alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero     = (alu_result == 32'd0);
        alu_overflow = ovf_drive;
    end

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_A = '0; cmd_B = '0; cmd_func = '0;
        rsp_ready = 1'b1; ovf_drive = 1'b0;
        #3;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy: got %b/%b expected 0/0", rsp_valid, busy); end
        checks++; if (alu_A !== 32'd0 || alu_B !== 32'd0 || alu_func !== 5'd0 || rsp_result !== 32'd0 || rsp_illegal !== 1'b0) begin
            errors++; $display("FAIL reset_regs: alu_A=%h alu_B=%h func=%b result=%h illegal=%b expected all 0", alu_A, alu_B, alu_func, rsp_result, rsp_illegal);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", cmd_ready); end
        $display("test_reset done");
    endtask

    task automatic test_add;
        @(negedge clk); cmd_valid = 1'b1; cmd_A = 32'd5; cmd_B = 32'd3; cmd_func = 5'b10110;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_edge0: valid=%b busy=%b expected 0/1", rsp_valid, busy); end
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || alu_A !== 32'd5 || alu_func !== 5'b10110) begin
            errors++; $display("FAIL add_edge1: valid=%b alu_A=%0d func=%b expected 0/5/10110", rsp_valid, alu_A, alu_func);
        end
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd8 || rsp_zero !== 1'b0 || rsp_illegal !== 1'b0) begin
            errors++; $display("FAIL add_rsp: valid=%b result=%0d zero=%b illegal=%b expected 1/8/0/0", rsp_valid, rsp_result, rsp_zero, rsp_illegal);
        end
        $display("rsp add: result=%0d zero=%b illegal=%b", rsp_result, rsp_zero, rsp_illegal);
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_drain: valid=%b busy=%b expected 0/0", rsp_valid, busy); end
    endtask

    task automatic test_mul;
        logic [31:0] a0, b0;
        logic [4:0]  f0;
        ovf_drive = 1'b1;
        @(negedge clk); cmd_valid = 1'b1; cmd_A = 32'd7; cmd_B = 32'd6; cmd_func = 5'b10000;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        a0 = alu_A; b0 = alu_B; f0 = alu_func;
        checks++; if (a0 !== 32'd7 || b0 !== 32'd6 || f0 !== 5'b10000) begin
            errors++; $display("FAIL mul_present: A=%0d B=%0d func=%b expected 7/6/10000", a0, b0, f0);
        end
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (alu_A !== a0 || alu_B !== b0 || alu_func !== f0 || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL mul_hold_%0d: A=%0d B=%0d func=%b valid=%b expected 7/6/10000/0", k, alu_A, alu_B, alu_func, rsp_valid);
            end
        end
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd42 || rsp_overflow !== 1'b0) begin
            errors++; $display("FAIL mul_rsp: valid=%b result=%0d ovf=%b expected 1/42/0", rsp_valid, rsp_result, rsp_overflow);
        end
        $display("rsp mul: result=%0d ovf=%b", rsp_result, rsp_overflow);
        ovf_drive = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_illegal;
        @(negedge clk); cmd_valid = 1'b1; cmd_A = 32'd9; cmd_B = 32'd9; cmd_func = 5'b01000;
        @(posedge clk);
        @(negedge clk); cmd_A = 32'hFFFF_FFFF; cmd_B = 32'hFFFF_FFFF; cmd_func = 5'b11010;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_result !== 32'd0 || alu_func !== 5'b01000) begin
            errors++; $display("FAIL illegal_rsp: valid=%b illegal=%b result=%h func=%b expected 1/1/0/01000", rsp_valid, rsp_illegal, rsp_result, alu_func);
        end
        $display("rsp illegal: result=%h illegal=%b", rsp_result, rsp_illegal);
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL illegal_drain: valid=%b expected 0", rsp_valid); end
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_illegal !== 1'b0 || alu_A !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL xor_rsp: valid=%b result=%h zero=%b illegal=%b A=%h expected 1/0/1/0/ffffffff", rsp_valid, rsp_result, rsp_zero, rsp_illegal, alu_A);
        end
        $display("rsp xor: result=%h zero=%b", rsp_result, rsp_zero);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [6:0] pat;
        pat = 7'b0100100;
        ovf_drive = 1'b1;
        @(negedge clk); cmd_valid = 1'b1; cmd_A = 32'd100; cmd_B = 32'd23; cmd_func = 5'b10110;
        @(posedge clk);
        @(negedge clk); cmd_A = 32'd1; cmd_B = 32'd4; cmd_func = 5'b00000;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (rsp_valid !== pat[k]) begin errors++; $display("FAIL b2b_valid_%0d: got %b expected %b", k, rsp_valid, pat[k]); end
            if (k == 2) begin
                checks++; if (rsp_result !== 32'd123 || rsp_overflow !== 1'b1) begin
                    errors++; $display("FAIL b2b_add: result=%0d ovf=%b expected 123/1", rsp_result, rsp_overflow);
                end
                $display("rsp b2b add: result=%0d ovf=%b", rsp_result, rsp_overflow);
            end
            if (k == 5) begin
                checks++; if (rsp_result !== 32'd16 || rsp_overflow !== 1'b0) begin
                    errors++; $display("FAIL b2b_shift: result=%0d ovf=%b expected 16/0", rsp_result, rsp_overflow);
                end
                $display("rsp b2b shift: result=%0d ovf=%b", rsp_result, rsp_overflow);
            end
        end
        ovf_drive = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_res [5];
        int n;
        exp_res[0] = 32'd4;  exp_res[1] = 32'd21; exp_res[2] = 32'd38;
        exp_res[3] = 32'd55; exp_res[4] = 32'd72;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_A = 32'(i * 16 + 3); cmd_B = 32'(i + 1); cmd_func = 5'b10110;
            checks++; if (cmd_ready !== (i < 5)) begin errors++; $display("FAIL bp_ready_%0d: got %b expected %b", i, cmd_ready, (i < 5)); end
            @(posedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 32'd4) begin
                errors++; $display("FAIL bp_hold_%0d: ready=%b valid=%b result=%0d expected 0/1/4", k, cmd_ready, rsp_valid, rsp_result);
            end
            @(posedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid === 1'b1) begin
                if (n < 5) begin
                    checks++; if (rsp_result !== exp_res[n]) begin
                        errors++; $display("FAIL bp_order_%0d: got %0d expected %0d", n, rsp_result, exp_res[n]);
                    end
                    $display("rsp drain %0d: result=%0d", n, rsp_result);
                end
                n++;
            end
            @(posedge clk); @(negedge clk);
        end
        checks++; if (n != 5) begin errors++; $display("FAIL bp_count: got %0d responses expected 5", n); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_idle: busy=%b ready=%b expected 0/1", busy, cmd_ready); end
    endtask

    task automatic test_reset_mid;
        int n;
        rsp_ready = 1'b1;
        @(negedge clk); cmd_valid = 1'b1; cmd_A = 32'd9; cmd_B = 32'd9; cmd_func = 5'b10000;
        @(posedge clk);
        @(negedge clk); cmd_A = 32'd1; cmd_B = 32'd1; cmd_func = 5'b10110;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (alu_A !== 32'd9 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre: A=%0d busy=%b expected 9/1", alu_A, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_A !== 32'd0 || alu_B !== 32'd0 || alu_func !== 5'd0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset: valid=%b busy=%b A=%h B=%h func=%b ready=%b expected all 0", rsp_valid, busy, alu_A, alu_B, alu_func, cmd_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_release: busy=%b ready=%b expected 0/1", busy, cmd_ready); end
        @(negedge clk); cmd_valid = 1'b1; cmd_A = 32'd20; cmd_B = 32'd22; cmd_func = 5'b10110;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd42) begin
            errors++; $display("FAIL mid_after: valid=%b result=%0d expected 1/42", rsp_valid, rsp_result);
        end
        $display("rsp after reset: result=%0d", rsp_result);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid === 1'b1) n++;
            @(posedge clk); @(negedge clk);
        end
        checks++; if (n != 1) begin errors++; $display("FAIL mid_extra: got %0d responses expected 1", n); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
